// File: rtl/graphics_window_display.sv
// graphics_window_display: draws a double-buffered video-RAM image at a
// runtime position and power-of-two scale, with optional border and a fixed
// background colour. Placed between the VGA timing generator and the pins.
module graphics_window_display #(
  parameter int unsigned          VGA_WIDTH    = 640,
  parameter int unsigned          VGA_HEIGHT   = 480,
  parameter int unsigned          COLOR_LEN    = 12,
  parameter int unsigned          IMG_W        = 128,
  parameter int unsigned          IMG_H        = 128,
  parameter int unsigned          RAM_LATENCY  = 2,
  parameter logic [COLOR_LEN-1:0] BG_COLOR     = 12'hfff,
  parameter int unsigned          BORDER_W     = 2,
  parameter logic [COLOR_LEN-1:0] BORDER_COLOR = 12'hf00
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      blank,
  input  logic [$clog2(VGA_WIDTH)-1:0]              vga_x,
  input  logic [$clog2(VGA_HEIGHT)-1:0]             vga_y,
  input  logic                                      vga_hsync_in,
  input  logic                                      vga_vsync_in,
  input  logic signed [$clog2(VGA_WIDTH):0]         cfg_x0,
  input  logic signed [$clog2(VGA_HEIGHT):0]        cfg_y0,
  input  logic [1:0]                                cfg_scale,
  input  logic                                      cfg_border_en,
  input  logic                                      swap_req,
  output logic                                      swap_ack,
  output logic                                      front_buf,
  output logic                                      ram_rden,
  output logic [$clog2(IMG_H)+$clog2(IMG_W):0]      ram_raddr,
  input  logic [COLOR_LEN-1:0]                      ram_rdata,
  output logic [COLOR_LEN-1:0]                      vga_col,
  output logic                                      vga_hsync_out,
  output logic                                      vga_vsync_out
);

  localparam int unsigned XW  = $clog2(VGA_WIDTH);
  localparam int unsigned YW  = $clog2(VGA_HEIGHT);
  localparam int unsigned IXW = $clog2(IMG_W);
  localparam int unsigned IYW = $clog2(IMG_H);
  localparam int unsigned AW  = 1 + IXW + IYW;
  localparam int unsigned L   = RAM_LATENCY + 1;
  localparam int          BW  = int'(BORDER_W);

  // Active (frame-shadowed) configuration
  logic signed [XW:0] r_x0;
  logic signed [YW:0] r_y0;
  logic [1:0]         r_scale;
  logic               r_border_en;

  // Frame / buffer control
  logic r_vs_prev;
  logic r_swap_pending;
  logic r_front_buf;
  logic r_swap_ack;
  logic w_fs;

  // Stage-1 RAM request
  logic          r_rden;
  logic [AW-1:0] r_raddr;

  // Delay lines; bit 0 is the stage-1 register, bit L-1 aligns with ram_rdata.
  // Visibility is carried as !blank so a cleared line reads as blanked.
  logic [L-1:0] r_vis_sr;
  logic [L-1:0] r_in_sr;
  logic [L-1:0] r_bd_sr;
  logic [L-1:0] r_hs_sr;
  logic [L-1:0] r_vs_sr;

  // Per-pixel geometry (computed wide so off-screen origins never wrap)
  logic signed [31:0] w_rx;
  logic signed [31:0] w_ry;
  logic signed [31:0] w_ext_w;
  logic signed [31:0] w_ext_h;
  logic               w_inside;
  logic               w_border;
  logic [IXW-1:0]     w_img_x;
  logic [IYW-1:0]     w_img_y;

  assign w_fs = ~vga_vsync_in & r_vs_prev;

  assign w_rx    = $signed(32'(vga_x)) - 32'(r_x0);
  assign w_ry    = $signed(32'(vga_y)) - 32'(r_y0);
  assign w_ext_w = $signed(32'(IMG_W) << r_scale);
  assign w_ext_h = $signed(32'(IMG_H) << r_scale);

  assign w_inside = ~blank
                  & (w_rx >= 0) & (w_rx < w_ext_w)
                  & (w_ry >= 0) & (w_ry < w_ext_h);

  assign w_border = r_border_en & ~blank & ~w_inside
                  & (w_rx >= -BW) & (w_rx < w_ext_w + BW)
                  & (w_ry >= -BW) & (w_ry < w_ext_h + BW);

  // Only meaningful when inside, where rx/ry are non-negative
  assign w_img_x = IXW'(w_rx >>> r_scale);
  assign w_img_y = IYW'(w_ry >>> r_scale);

  // Frame start detection, config shadowing and buffer swap handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev      <= 1'b0;
      r_swap_pending <= 1'b0;
      r_front_buf    <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_x0           <= '0;
      r_y0           <= '0;
      r_scale        <= '0;
      r_border_en    <= 1'b0;
    end else begin
      r_vs_prev  <= vga_vsync_in;
      r_swap_ack <= 1'b0;
      if (w_fs) begin
        r_x0           <= cfg_x0;
        r_y0           <= cfg_y0;
        r_scale        <= cfg_scale;
        r_border_en    <= cfg_border_en;
        r_swap_pending <= 1'b0;
        if (r_swap_pending | swap_req) begin
          r_front_buf <= ~r_front_buf;
          r_swap_ack  <= 1'b1;
        end
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  // Stage 1 RAM request plus pixel-class and sync delay lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rden   <= 1'b0;
      r_raddr  <= '0;
      r_vis_sr <= '0;
      r_in_sr  <= '0;
      r_bd_sr  <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
    end else begin
      r_rden <= w_inside;
      if (w_inside) begin
        r_raddr <= {r_front_buf, w_img_y, w_img_x};
      end
      r_vis_sr <= {r_vis_sr[L-2:0], ~blank};
      r_in_sr  <= {r_in_sr[L-2:0], w_inside};
      r_bd_sr  <= {r_bd_sr[L-2:0], w_border};
      r_hs_sr  <= {r_hs_sr[L-2:0], vga_hsync_in};
      r_vs_sr  <= {r_vs_sr[L-2:0], vga_vsync_in};
    end
  end

  // Colour select from the flags that line up with returning RAM data
  always_comb begin
    vga_col = '0;
    if (r_vis_sr[L-1]) begin
      if (r_in_sr[L-1]) begin
        vga_col = ram_rdata;
      end else if (r_bd_sr[L-1]) begin
        vga_col = BORDER_COLOR;
      end else begin
        vga_col = BG_COLOR;
      end
    end
  end

  assign swap_ack      = r_swap_ack;
  assign front_buf     = r_front_buf;
  assign ram_rden      = r_rden;
  assign ram_raddr     = r_raddr;
  assign vga_hsync_out = r_hs_sr[L-1];
  assign vga_vsync_out = r_vs_sr[L-1];

endmodule

// File: tb/tb_graphics_window_display.sv
// Directed bench for graphics_window_display (640x480, 128x128 image,
// RAM latency 2 so end-to-end latency is 3 cycles).
module tb_graphics_window_display;

  localparam int RAM_LAT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               blank;
  logic [9:0]         vga_x;
  logic [8:0]         vga_y;
  logic               hs_in;
  logic               vs_in;
  logic signed [10:0] cfg_x0;
  logic signed [9:0]  cfg_y0;
  logic [1:0]         cfg_scale;
  logic               cfg_border_en;
  logic               swap_req;
  logic               swap_ack;
  logic               front_buf;
  logic               ram_rden;
  logic [14:0]        ram_raddr;
  logic [11:0]        ram_rdata;
  logic [11:0]        vga_col;
  logic               hs_out;
  logic               vs_out;

  int n_checks = 0;
  int n_err    = 0;

  graphics_window_display #(
    .VGA_WIDTH   (640),
    .VGA_HEIGHT  (480),
    .COLOR_LEN   (12),
    .IMG_W       (128),
    .IMG_H       (128),
    .RAM_LATENCY (RAM_LAT),
    .BG_COLOR    (12'hfff),
    .BORDER_W    (2),
    .BORDER_COLOR(12'hf00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blank        (blank),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_hsync_in (hs_in),
    .vga_vsync_in (vs_in),
    .cfg_x0       (cfg_x0),
    .cfg_y0       (cfg_y0),
    .cfg_scale    (cfg_scale),
    .cfg_border_en(cfg_border_en),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_buf    (front_buf),
    .ram_rden     (ram_rden),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .vga_col      (vga_col),
    .vga_hsync_out(hs_out),
    .vga_vsync_out(vs_out)
  );

  always #5 clk = ~clk;

  // RAM model: content = low address bits ^ 12'h123, RAM_LAT cycles latency
  logic [11:0] ram_pipe [RAM_LAT] = '{default: '0};
  always_ff @(posedge clk) begin
    ram_pipe[0] <= 12'(ram_raddr) ^ 12'h123;
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rdata = ram_pipe[RAM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame start: vsync falls for one cycle during blanking
  task automatic fs();
    blank = 1'b1;
    vs_in = 1'b0;
    step();
    vs_in = 1'b1;
  endtask

  // Drive one visible pixel, then blanking; check stage-1 request and the
  // colour exactly 3 cycles after the pixel was presented.
  task automatic pix(input string tag, input int x, input int y, input logic exp_rden,
                     input logic [14:0] exp_addr, input logic [11:0] exp_col);
    vga_x = 10'(x);
    vga_y = 9'(y);
    blank = 1'b0;
    step();
    blank = 1'b1;
    chk({tag, ".rden"}, 32'(ram_rden), 32'(exp_rden));
    if (exp_rden) chk({tag, ".raddr"}, 32'(ram_raddr), 32'(exp_addr));
    step();
    chk({tag, ".early"}, 32'(vga_col), 32'h0);
    step();
    chk({tag, ".col"}, 32'(vga_col), 32'(exp_col));
  endtask

  initial begin
    rst = 1'b1; blank = 1'b1; vga_x = '0; vga_y = '0; hs_in = 1'b1; vs_in = 1'b1;
    cfg_x0 = '0; cfg_y0 = '0; cfg_scale = '0; cfg_border_en = 1'b0; swap_req = 1'b0;
    step(); step();
    chk("rst.col",   32'(vga_col),   32'h0);
    chk("rst.rden",  32'(ram_rden),  32'h0);
    chk("rst.raddr", 32'(ram_raddr), 32'h0);
    chk("rst.front", 32'(front_buf), 32'h0);
    chk("rst.ack",   32'(swap_ack),  32'h0);
    chk("rst.hs",    32'(hs_out),    32'h0);
    chk("rst.vs",    32'(vs_out),    32'h0);
    rst = 1'b0;
    step();
    chk("sync.lat1", 32'(hs_out), 32'h0);
    step(); step();
    chk("sync.lat3", 32'(hs_out), 32'h1);
    chk("vsync.lat3", 32'(vs_out), 32'h1);

    // hsync low pulse appears exactly 3 cycles later
    hs_in = 1'b0; step(); hs_in = 1'b1;
    chk("hs.pre", 32'(hs_out), 32'h1);
    step(); step();
    chk("hs.low", 32'(hs_out), 32'h0);
    step();
    chk("hs.back", 32'(hs_out), 32'h1);

    // Centred default
    cfg_x0 = 11'sd64; cfg_y0 = -10'sd16; cfg_scale = 2'd2; cfg_border_en = 1'b0;
    fs();
    chk("fs.noack", 32'(swap_ack), 32'h0);
    pix("centre", 64, 0, 1'b1, 15'h0200, 12'h323);

    // Background and blanked image pixel
    pix("bg", 0, 0, 1'b0, 15'h0, 12'hfff);
    chk("bg.hold", 32'(ram_raddr), 32'h0200);
    vga_x = 10'd64; vga_y = 9'd0; blank = 1'b1;
    step();
    chk("blank.rden", 32'(ram_rden), 32'h0);
    step(); step();
    chk("blank.col", 32'(vga_col), 32'h0);

    // Border
    cfg_x0 = 11'sd100; cfg_y0 = 10'sd100; cfg_scale = 2'd0; cfg_border_en = 1'b1;
    fs();
    pix("bd.98",  98,  150, 1'b0, 15'h0,    12'hf00);
    pix("bd.97",  97,  150, 1'b0, 15'h0,    12'hfff);
    pix("bd.100", 100, 150, 1'b1, 15'h1900, 12'h823);
    pix("bd.227", 227, 150, 1'b1, 15'h197f, 12'h85c);
    pix("bd.228", 228, 150, 1'b0, 15'h0,    12'hf00);
    pix("bd.229", 229, 150, 1'b0, 15'h0,    12'hf00);
    pix("bd.230", 230, 150, 1'b0, 15'h0,    12'hfff);
    pix("bd.top", 150, 98,  1'b0, 15'h0,    12'hf00);

    // Clipping
    cfg_x0 = 11'sd600; cfg_y0 = 10'sd0; cfg_scale = 2'd1; cfg_border_en = 1'b0;
    fs();
    pix("clip.r", 639, 10, 1'b1, 15'h0293, 12'h3b0);
    cfg_x0 = -11'sd10;
    fs();
    pix("clip.l", 0, 10, 1'b1, 15'h0285, 12'h3a6);

    // Two mid-frame requests give one flip at the next frame start
    swap_req = 1'b1; step(); swap_req = 1'b0; step();
    swap_req = 1'b1; step(); swap_req = 1'b0; step();
    chk("swap.mid.front", 32'(front_buf), 32'h0);
    chk("swap.mid.ack",   32'(swap_ack),  32'h0);
    fs();
    chk("swap.fs.front", 32'(front_buf), 32'h1);
    chk("swap.fs.ack",   32'(swap_ack),  32'h1);
    step();
    chk("swap.ack.clr",  32'(swap_ack),  32'h0);
    fs();
    chk("swap.once.front", 32'(front_buf), 32'h1);
    chk("swap.once.ack",   32'(swap_ack),  32'h0);
    pix("swap.addr", 0, 10, 1'b1, 15'h4285, 12'h3a6);

    // Request coincident with frame start
    swap_req = 1'b1; fs(); swap_req = 1'b0;
    chk("swap.co.front", 32'(front_buf), 32'h0);
    chk("swap.co.ack",   32'(swap_ack),  32'h1);
    step();

    // Shadowing: mid-frame change ignored until frame start
    cfg_x0 = 11'sd0;
    pix("shadow.mid", 0, 10, 1'b1, 15'h0285, 12'h3a6);
    fs();
    pix("shadow.fs", 0, 10, 1'b1, 15'h0280, 12'h3a3);

    // Reset mid-line with front buffer set
    swap_req = 1'b1; step(); swap_req = 1'b0;
    fs();
    chk("pre.rst.front", 32'(front_buf), 32'h1);
    vga_x = 10'd4; vga_y = 9'd10; blank = 1'b0;
    step();
    vga_x = 10'd5;
    step();
    rst = 1'b1;
    step();
    chk("mrst.col",   32'(vga_col),   32'h0);
    chk("mrst.front", 32'(front_buf), 32'h0);
    chk("mrst.rden",  32'(ram_rden),  32'h0);
    chk("mrst.raddr", 32'(ram_raddr), 32'h0);
    rst = 1'b0; blank = 1'b1;
    step(); step(); step();
    pix("post.rst", 5, 3, 1'b1, 15'h0185, 12'h0a6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
